// File: rtl/div_share_pkg.sv
// div_share_pkg: shared widths, request/result records and helpers for the divider share scheduler
package div_share_pkg;
  localparam int MAX_NUM_WT = 16;
  localparam int MAX_NUM_HT = 16;
  localparam int MAX_NUM_K = 16;
  localparam int NUM_REQ = 4;
  localparam int N = $clog2(MAX_NUM_WT * MAX_NUM_HT) + 2;
  localparam int M = $clog2(MAX_NUM_WT) + 1;
  localparam int KW = $clog2(MAX_NUM_K) + 1;
  localparam int LAT = N;
  localparam int IDW = $clog2(NUM_REQ);
  typedef struct packed {
    logic [N-1:0]  dividend;
    logic [M-1:0]  divisor;
    logic [KW-1:0] k;
  } div_req_t;
  typedef struct packed {
    logic [N-1:0]  quotient;
    logic [M-1:0]  remainder;
    logic [KW-1:0] k;
  } div_res_t;
  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDW-1:0] id);
    return NUM_REQ'(1) << id;
  endfunction
endpackage

// File: rtl/div_share_sched_if.sv
// div_share_if: requester, divider and result signals of the divider share scheduler
interface div_share_if;
  import div_share_pkg::*;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*N-1:0]  req_dividend;
  logic [NUM_REQ*M-1:0]  req_divisor;
  logic [NUM_REQ*KW-1:0] req_k;
  logic                  div_data_rdy;
  logic [N-1:0]          div_dividend;
  logic [M-1:0]          div_divisor;
  logic [KW-1:0]         div_k_in;
  logic                  div_stall;
  logic                  div_res_rdy;
  logic [N-1:0]          div_quotient;
  logic [M-1:0]          div_remainder;
  logic [KW-1:0]         div_k_out;
  logic [NUM_REQ-1:0]    res_valid;
  logic [NUM_REQ-1:0]    res_ready;
  logic [N-1:0]          res_quotient;
  logic [M-1:0]          res_remainder;
  logic [KW-1:0]         res_k;
  logic                  err_div0;
  logic                  err_orphan;
  modport master (
    input  req_valid, req_dividend, req_divisor, req_k,
    input  div_res_rdy, div_quotient, div_remainder, div_k_out, res_ready,
    output req_ready, div_data_rdy, div_dividend, div_divisor, div_k_in, div_stall,
    output res_valid, res_quotient, res_remainder, res_k, err_div0, err_orphan
  );
  modport slave (
    output req_valid, req_dividend, req_divisor, req_k,
    output div_res_rdy, div_quotient, div_remainder, div_k_out, res_ready,
    input  req_ready, div_data_rdy, div_dividend, div_divisor, div_k_in, div_stall,
    input  res_valid, res_quotient, res_remainder, res_k, err_div0, err_orphan
  );
endinterface

// File: rtl/div_share_sched_rr_arbiter.sv
// rr_arbiter: one-hot round-robin grant starting at ptr_i, with the pointer to use after the grant
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  localparam int IDW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [IDW-1:0]     ptr_i,
  input  logic               en_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDW-1:0]     ptr_nxt_o
);
  logic [IDW-1:0] idx;
  // Scan from farthest to nearest so the nearest valid requester overrides.
  always_comb begin
    gnt_o = '0;
    ptr_nxt_o = ptr_i;
    idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = IDW'((int'(ptr_i) + i) % NUM_REQ);
      if (en_i && valid_i[idx]) begin
        gnt_o = '0;
        gnt_o[idx] = 1'b1;
        ptr_nxt_o = IDW'((int'(idx) + 1) % NUM_REQ);
      end
    end
  end
endmodule

// File: rtl/div_share_sched.sv
// div_share_sched: round-robin sharing of one pipelined divider, routing in-order results back to their owners
module div_share_sched
  import div_share_pkg::*;
(
  input logic         clk,
  input logic         rst,
  div_share_if.master bus
);
  localparam int PW = $clog2(LAT);
  localparam int CW = $clog2(LAT + 1);
  div_req_t           req [NUM_REQ];
  div_req_t           sel;
  logic [NUM_REQ-1:0] gnt;
  logic [IDW-1:0]     rr_q, rr_d, gid, head_id;
  logic [IDW-1:0]     fifo_q [LAT];
  logic [PW-1:0]      wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               err_div0_q, err_div0_d, err_orphan_q, err_orphan_d;
  logic               have, issue_ok, issue, pop;
  always_comb begin
    gid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req[i].dividend = bus.req_dividend[i*N +: N];
      req[i].divisor = bus.req_divisor[i*M +: M];
      req[i].k = bus.req_k[i*KW +: KW];
      if (gnt[i]) gid = IDW'(i);
    end
  end
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .valid_i  (bus.req_valid),
    .ptr_i    (rr_q),
    .en_i     (issue_ok),
    .gnt_o    (gnt),
    .ptr_nxt_o(rr_d)
  );
  // A result arriving with nothing in flight is an orphan: dropped, never stalls.
  assign head_id = fifo_q[rd_q];
  assign have = cnt_q != '0;
  assign bus.div_stall = bus.div_res_rdy & have & ~bus.res_ready[head_id];
  assign issue_ok = ~rst & ~bus.div_stall & (cnt_q < CW'(LAT));
  assign issue = |gnt;
  assign pop = bus.div_res_rdy & have & bus.res_ready[head_id];
  assign sel = issue ? req[gid] : '0;
  assign bus.req_ready = gnt;
  assign bus.div_data_rdy = issue;
  assign bus.div_dividend = sel.dividend;
  assign bus.div_divisor = sel.divisor;
  assign bus.div_k_in = sel.k;
  assign bus.res_valid = (bus.div_res_rdy & have) ? onehot(head_id) : '0;
  assign bus.res_quotient = bus.div_quotient;
  assign bus.res_remainder = bus.div_remainder;
  assign bus.res_k = bus.div_k_out;
  assign bus.err_div0 = err_div0_q;
  assign bus.err_orphan = err_orphan_q;
  always_comb begin
    wr_d = !issue ? wr_q : (wr_q == PW'(LAT - 1)) ? '0 : wr_q + PW'(1);
    rd_d = !pop ? rd_q : (rd_q == PW'(LAT - 1)) ? '0 : rd_q + PW'(1);
    cnt_d = cnt_q + CW'(issue) - CW'(pop);
    err_div0_d = err_div0_q | (issue & (sel.divisor == '0));
    err_orphan_d = err_orphan_q | (bus.div_res_rdy & ~have);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= '0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      err_div0_q <= 1'b0;
      err_orphan_q <= 1'b0;
    end else begin
      rr_q <= rr_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      err_div0_q <= err_div0_d;
      err_orphan_q <= err_orphan_d;
    end
  end
  always_ff @(posedge clk) begin
    if (issue) fifo_q[wr_q] <= gid;
  end
endmodule

// File: doc/div_share_sched.md
Name: div_share_sched

Overview:
- Shares the single pipelined coordinate divider (index / Wt -> row, column) between NUM_REQ requesters, such as PE output-coordinate units.
- Grants one request per cycle, round-robin, and issues it to the divider with its k tag.
- Keeps an in-order FIFO of requester IDs for in-flight operations and routes each result back to its owner.
- Stalls the whole divider pipeline when the owner of the head result is not ready.

Parameters:
- NUM_REQ, 4, number of requesters.
- N, $clog2(`max_num_Wt*`max_num_Ht)+2, dividend width.
- M, $clog2(`max_num_Wt)+1, divisor and remainder width.
- KW, $clog2(`max_num_K)+1, k tag width.
- LAT, N, divider pipeline depth in cycles when not stalled. This is also the ID FIFO depth.
- IDW, $clog2(NUM_REQ), requester ID width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester grant; one-hot or zero
- req_dividend  in  NUM_REQ*N  packed dividends
- req_divisor  in  NUM_REQ*M  packed divisors
- req_k  in  NUM_REQ*KW  packed k tags
- div_data_rdy  out  1  issue strobe to the divider
- div_dividend  out  N  to the divider
- div_divisor  out  M  to the divider
- div_k_in  out  KW  to the divider
- div_stall  out  1  freezes all divider stages
- div_res_rdy  in  1  divider result valid
- div_quotient  in  N  divider quotient
- div_remainder  in  M  divider remainder
- div_k_out  in  KW  divider k tag out
- res_valid  out  NUM_REQ  one-hot result valid to the owning requester
- res_ready  in  NUM_REQ  per-requester result ready
- res_quotient  out  N  shared result bus
- res_remainder  out  M  shared result bus
- res_k  out  KW  shared result bus
- err_div0  out  1  sticky: a request was issued with divisor 0
- err_orphan  out  1  sticky: div_res_rdy arrived while the ID FIFO was empty

Behaviour:
- Clocking and reset: single clock, clk. Reset is synchronous and active-high on rst.
- Reset values: all outputs 0; FIFO pointers and count 0; round-robin pointer 0 (requester 0 has highest priority).
- Reset mid-operation: in-flight entries are discarded. The divider shares rst, so no orphan results appear.
- Stall:
  - div_stall = div_res_rdy & ~res_ready[fifo_head_id], combinational.
  - A stalled head result stays on the bus unchanged until accepted.
- Issue condition: issue_ok = ~div_stall & (count < LAT).
  - count < LAT is a safety bound; with in-order fixed latency the count never exceeds LAT.
- Arbitration:
  - When issue_ok, grant the first valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  - req_ready[g] = 1 for the granted requester g only; combinational.
  - On grant, rr_ptr <= g+1 modulo NUM_REQ.
  - With no valid requester or issue_ok = 0, req_ready = 0 and rr_ptr holds.
- Issue:
  - div_data_rdy = grant; the div_* data outputs mux the granted slice combinationally. When idle, data outputs are 0.
  - The same cycle, push g into the ID FIFO.
  - If the issued divisor is 0, set err_div0. The operation still proceeds, and its result value is don't-care.
- Result routing:
  - res_valid = div_res_rdy ? onehot(fifo_head_id) : 0.
  - res_quotient, res_remainder and res_k pass through from the divider.
  - Pop on div_res_rdy & res_ready[head].
- Simultaneous issue and pop: count is unchanged and both pointers advance. Pointers wrap at LAT.
- Orphan result: div_res_rdy with count == 0 sets err_orphan. That result is dropped: res_valid = 0 and no stall.
- Latency: a request granted in cycle t delivers res_valid in cycle t+LAT, plus the number of stalled cycles in between.
- Throughput: one issue per cycle when no stall occurs.
- Requester interface rules:
  - Requesters must hold req_valid and the request data until req_ready.
  - The bench must model the divider so that busy freezes every stage.

Decomposition:
- Package div_share_pkg holds:
  - localparams N, M, KW and LAT;
  - the typedef div_req_t {dividend, divisor, k};
  - the typedef div_res_t {quotient, remainder, k}.
- Sub-module rr_arbiter (NUM_REQ): valid vector, pointer and enable in; one-hot grant and next pointer out.
- The ID FIFO is an inline register array.

Test Plan:
- Single request: req0 = {dividend 37, divisor 8, k 3}, no contention -> req_ready[0] in the same cycle; after LAT cycles res_valid = 4'b0001, quotient 4, remainder 5, k 3.
- Fairness: all four requesters valid continuously -> grants in order 0,1,2,3,0,...; results return in the same order, each to its own res_valid bit.
- Backpressure: res_ready[1] = 0 for 5 cycles when the head result belongs to requester 1 -> div_stall = 1 and req_ready = 0 for those 5 cycles; the result is held steady; no loss or duplication after release.
- Back-to-back issue and pop at steady state: count stays constant, and pointers wrap past LAT without corruption over 3*LAT operations checked against a scoreboard.
- Divisor 0 issued by requester 2 -> err_div0 = 1 and stays set; subsequent operations still complete correctly.
- Reset asserted with 3 operations in flight -> all outputs 0 next cycle, count 0, rr_ptr 0; a fresh request afterwards completes with correct values.
